dmem_controller: RTL and testbench

- Parametrised data-memory block for the CPU load/store path.
- Generalises the fixed 1024-word, single-cycle data memory with configurable width, depth and read latency.
- Uses a valid/ready request port, a registered read-response channel with an error flag, and a hardware initialisation sweep after reset in place of a one-cycle array clear.
- Sits between the execute-stage load/store unit and the data array.

---
 rtl/dmem_controller.sv | 168 ++++++++++++++++
 tb/tb_dmem_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_controller.sv
// Parametrised data memory with a valid/ready request port, a pipelined read response and a post-reset clearing sweep.
// Optional per-word even parity is enabled by defining DMEM_PARITY_EN.
module dmem_controller #(
    parameter int WORD_SIZE    = 19,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_SIZE-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
    localparam int MEM_W = WORD_SIZE + 1;
`else
    localparam int MEM_W = WORD_SIZE;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    PTR_LAST  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

`ifdef DMEM_PARITY_EN
    // Stored word is {parity, data}; parity makes the XOR of all bits zero.
    function automatic logic [MEM_W-1:0] encode_word(input logic [WORD_SIZE-1:0] d);
        return {^d, d};
    endfunction

    function automatic logic parity_fail(input logic [MEM_W-1:0] w);
        return ^w;
    endfunction
`endif

    state_t                state;
    logic [IDX_W-1:0]      ptr;
    logic [MEM_W-1:0]      mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [MEM_W-1:0]      wr_word;

    logic                  vld_p1;
    logic [MEM_W-1:0]      data_p1;
    logic                  oor_p1;
    logic [WORD_SIZE-1:0]  word_p1;
    logic                  err_p1;

    logic                  out_vld;
    logic [WORD_SIZE-1:0]  out_data;
    logic                  out_err;

    assign accept   = req_valid && req_ready;
    assign in_range = {1'b0, req_addr} < DEPTH_LIM;
    assign idx      = req_addr[IDX_W-1:0];

`ifdef DMEM_PARITY_EN
    assign wr_word = encode_word(req_wdata);
`else
    assign wr_word = req_wdata;
`endif

    // Control FSM: sweep every word once, then accept requests indefinitely.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_INIT;
            ptr       <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    if (ptr == PTR_LAST) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

    // Array update: sweep clears have priority; out-of-range writes are dropped.
    always_ff @(posedge CLK) begin
        if (state == ST_INIT) begin
            mem[ptr] <= '0;
        end else if (accept && req_we && in_range) begin
            mem[idx] <= wr_word;
        end
    end

    // Stage p1: array sampled at the read acceptance edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept && !req_we;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && !req_we) begin
            data_p1 <= in_range ? mem[idx] : '0;
            oor_p1  <= !in_range;
        end
    end

    assign word_p1 = data_p1[WORD_SIZE-1:0];
`ifdef DMEM_PARITY_EN
    assign err_p1 = oor_p1 || parity_fail(data_p1);
`else
    assign err_p1 = oor_p1;
`endif

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 vld_p2;
            logic [WORD_SIZE-1:0] data_p2;
            logic                 err_p2;

            // Stage p2: extra output register for the two-cycle configuration.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    vld_p2 <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                end
            end

            always_ff @(posedge CLK) begin
                data_p2 <= word_p1;
                err_p2  <= err_p1;
            end

            assign out_vld  = vld_p2;
            assign out_data = data_p2;
            assign out_err  = err_p2;
        end else begin : g_lat1
            assign out_vld  = vld_p1;
            assign out_data = word_p1;
            assign out_err  = err_p1;
        end
    endgenerate

    // Data registers carry no reset, so the response is qualified by valid.
    assign rsp_valid = out_vld;
    assign rsp_rdata = out_vld ? out_data : '0;
    assign rsp_err   = out_vld && out_err;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller: a 1024-word single-latency instance and a
// 1000-word two-cycle-latency instance share one request stream.
module tb_dmem_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [18:0] req_wdata;

    logic        ready_a, vld_a, err_a, busy_a;
    logic [18:0] rdata_a;
    logic        ready_b, vld_b, err_b, busy_b;
    logic [18:0] rdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_controller #(.WORD_SIZE(19), .DEPTH(1024), .ADDR_WIDTH(10), .READ_LATENCY(1)) u_a (
        .CLK(clk), .RESET(rst),
        .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld_a), .rsp_rdata(rdata_a), .rsp_err(err_a), .init_busy(busy_a)
    );

    dmem_controller #(.WORD_SIZE(19), .DEPTH(1000), .ADDR_WIDTH(10), .READ_LATENCY(2)) u_b (
        .CLK(clk), .RESET(rst),
        .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld_b), .rsp_rdata(rdata_b), .rsp_err(err_b), .init_busy(busy_b)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [9:0]  addr;
        logic [18:0] wdata;
        logic [18:0] ra;
        logic        ea;
        logic [18:0] rb;
        logic        eb;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [9:0] a, input logic [18:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Count busy samples starting right after RESET is released.
    task automatic init_sweep(input string tag);
        int ca = 0;
        int cb = 0;
        int bad = 0;
        for (int i = 0; i < 1100; i++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (ready_a === busy_a || ready_b === busy_b) bad++;
            tick();
        end
        chk({tag, " init_cycles_a"}, ca, 1024);
        chk({tag, " init_cycles_b"}, cb, 1000);
        chk({tag, " ready_vs_busy"}, bad, 0);
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.we, v.addr, v.wdata);
        chk($sformatf("%s a_vld", v.name), vld_a, !v.we);
        chk($sformatf("%s b_early", v.name), vld_b, 1'b0);
        if (!v.we) begin
            chk($sformatf("%s a_data", v.name), rdata_a, v.ra);
            chk($sformatf("%s a_err", v.name), err_a, v.ea);
        end
        tick();
        chk($sformatf("%s a_pulse", v.name), vld_a, 1'b0);
        chk($sformatf("%s b_vld", v.name), vld_b, !v.we);
        if (!v.we) begin
            chk($sformatf("%s b_data", v.name), rdata_b, v.rb);
            chk($sformatf("%s b_err", v.name), err_b, v.eb);
        end
        tick();
        chk($sformatf("%s b_pulse", v.name), vld_b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vec_t v;

        vecs[0]  = '{"r5",     1'b0, 10'd5,    19'h00000, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[1]  = '{"w3",     1'b1, 10'd3,    19'h7FFFF, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[2]  = '{"r3",     1'b0, 10'd3,    19'h00000, 19'h7FFFF, 1'b0, 19'h7FFFF, 1'b0};
        vecs[3]  = '{"w1000",  1'b1, 10'd1000, 19'h00001, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[4]  = '{"r1000",  1'b0, 10'd1000, 19'h00000, 19'h00001, 1'b0, 19'h00000, 1'b1};
        vecs[5]  = '{"r999",   1'b0, 10'd999,  19'h00000, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[6]  = '{"w999",   1'b1, 10'd999,  19'h2AAAA, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[7]  = '{"r999b",  1'b0, 10'd999,  19'h00000, 19'h2AAAA, 1'b0, 19'h2AAAA, 1'b0};
        vecs[8]  = '{"w1023",  1'b1, 10'd1023, 19'h00003, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[9]  = '{"r1023",  1'b0, 10'd1023, 19'h00000, 19'h00003, 1'b0, 19'h00000, 1'b1};
        vecs[10] = '{"w3b",    1'b1, 10'd3,    19'h40001, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[11] = '{"r3b",    1'b0, 10'd3,    19'h00000, 19'h40001, 1'b0, 19'h40001, 1'b0};
        vecs[12] = '{"w0",     1'b1, 10'd0,    19'h55555, 19'h00000, 1'b0, 19'h00000, 1'b0};
        vecs[13] = '{"r0",     1'b0, 10'd0,    19'h00000, 19'h55555, 1'b0, 19'h55555, 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) tick();

        chk("rst ready_a", ready_a, 1'b0);
        chk("rst ready_b", ready_b, 1'b0);
        chk("rst vld_a", vld_a, 1'b0);
        chk("rst vld_b", vld_b, 1'b0);
        chk("rst rdata_a", rdata_a, 19'h0);
        chk("rst err_a", err_a, 1'b0);
        chk("rst busy_a", busy_a, 1'b1);
        chk("rst busy_b", busy_b, 1'b1);

        rst = 1'b0;
        init_sweep("boot");

        for (int i = 0; i < 14; i++) begin
            apply_vec(vecs[i]);
        end

        // Write then two reads on consecutive cycles.
        drive(1'b1, 10'd10, 19'h12345);
        chk("b2b w_vld_a", vld_a, 1'b0);
        chk("b2b w_vld_b", vld_b, 1'b0);
        drive(1'b0, 10'd10, 19'h0);
        chk("b2b r10_vld_a", vld_a, 1'b1);
        chk("b2b r10_data_a", rdata_a, 19'h12345);
        chk("b2b r10_early_b", vld_b, 1'b0);
        drive(1'b0, 10'd11, 19'h0);
        chk("b2b r11_vld_a", vld_a, 1'b1);
        chk("b2b r11_data_a", rdata_a, 19'h0);
        chk("b2b r10_vld_b", vld_b, 1'b1);
        chk("b2b r10_data_b", rdata_b, 19'h12345);
        tick();
        chk("b2b end_vld_a", vld_a, 1'b0);
        chk("b2b r11_vld_b", vld_b, 1'b1);
        chk("b2b r11_data_b", rdata_b, 19'h0);
        tick();
        chk("b2b end_vld_b", vld_b, 1'b0);

        // Reset right after a read is accepted: nothing may come out.
        drive(1'b0, 10'd7, 19'h0);
        rst = 1'b1;
        #1;
        chk("midrst vld_a", vld_a, 1'b0);
        chk("midrst busy_a", busy_a, 1'b1);
        chk("midrst ready_b", ready_b, 1'b0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (vld_a || vld_b) seen++;
        end
        chk("midrst no_rsp", seen, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (vld_a || vld_b) seen++;
            tick();
        end
        chk("midrst no_rsp_after", seen, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_sweep("rerun");

        v = '{"r3clr", 1'b0, 10'd3, 19'h0, 19'h00000, 1'b0, 19'h00000, 1'b0};
        apply_vec(v);

`ifdef DMEM_PARITY_EN
        v = '{"pw4", 1'b1, 10'd4, 19'h00001, 19'h0, 1'b0, 19'h0, 1'b0};
        apply_vec(v);
        u_a.mem[4][0] = ~u_a.mem[4][0];
        u_b.mem[4][0] = ~u_b.mem[4][0];
        v = '{"pr4", 1'b0, 10'd4, 19'h0, 19'h00000, 1'b1, 19'h00000, 1'b1};
        apply_vec(v);
        v = '{"pw5", 1'b1, 10'd5, 19'h00003, 19'h0, 1'b0, 19'h0, 1'b0};
        apply_vec(v);
        v = '{"pr5", 1'b0, 10'd5, 19'h0, 19'h00003, 1'b0, 19'h00003, 1'b0};
        apply_vec(v);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
